// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the Tx sequencing controller and the UART transmit module.
interface uart_tx_ctrl_if #(
  parameter int DW = 8,
  parameter int CW = 5
);
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic [CW-1:0] tx_conf;
  logic          tx_busy;
  logic          tx_done;

  modport master (output tx_start, tx_data, tx_conf, input tx_busy, tx_done);
  modport slave  (input tx_start, tx_data, tx_conf, output tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_ctrl.sv
// Tx sequencing controller: feeds characters from a FWFT FIFO or a direct request to the UART
// transmit module, with a start watchdog. Optional inter-character gap: define UART_TX_GAP_EN.
module uart_tx_ctrl #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int TOTAL_CONF_W    = 5,
  parameter int CHAR_COUNT_W    = 16,
  parameter int START_TIMEOUT   = 1023,
  parameter int GAP_W           = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       baud_en_i,
  input  logic                       tx_en_i,
  input  logic                       tx_fifo_en_i,
  input  logic [TOTAL_CONF_W-1:0]    tx_conf_i,
  input  logic                       tx_req_i,
  input  logic [MAX_UART_DATA_W-1:0] tx_data_i,
  input  logic                       fifo_empty_i,
  input  logic [MAX_UART_DATA_W-1:0] fifo_data_i,
  input  logic [GAP_W-1:0]           gap_i,
  output logic                       fifo_pop_o,
  output logic                       ctrl_busy_o,
  output logic                       req_drop_o,
  output logic                       timeout_o,
  output logic [CHAR_COUNT_W-1:0]    char_count_o,
  uart_tx_ctrl_if.master             tx_if
);
  localparam int WD_W = $clog2(START_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(START_TIMEOUT);

`ifdef UART_TX_GAP_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP} state_e;
  logic [GAP_W-1:0] gap_q, gap_d;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT} state_e;
  logic unused_gap;
  assign unused_gap = ^{gap_i, baud_en_i};
`endif

  state_e                      state_q, state_d;
  logic                        mode_q, mode_d;
  logic [MAX_UART_DATA_W-1:0]  dir_q, dir_d, data_q, data_d;
  logic [TOTAL_CONF_W-1:0]     conf_q, conf_d;
  logic [WD_W-1:0]             wd_q, wd_d;
  logic [CHAR_COUNT_W-1:0]     cnt_q, cnt_d;
  logic                        pop, start, drop, tmo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      dir_q   <= '0;
      data_q  <= '0;
      conf_q  <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
`ifdef UART_TX_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      conf_q  <= conf_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
`ifdef UART_TX_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    data_d  = data_q;
    conf_d  = conf_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
`ifdef UART_TX_GAP_EN
    gap_d   = gap_q;
`endif
    pop   = 1'b0;
    start = 1'b0;
    tmo   = 1'b0;
    // Direct requests are only honoured from IDLE with the controller enabled.
    drop  = !tx_fifo_en_i && tx_req_i && (state_q != IDLE || !tx_en_i);
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (tx_en_i && tx_fifo_en_i && !fifo_empty_i) begin
          mode_d  = 1'b1;
          state_d = LOAD;
        end else if (tx_en_i && !tx_fifo_en_i && tx_req_i) begin
          mode_d  = 1'b0;
          dir_d   = tx_data_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d  = mode_q ? fifo_data_i : dir_q;
        conf_d  = tx_conf_i;
        pop     = mode_q;
        wd_d    = '0;
        state_d = START;
      end
      START: begin
        if (tx_if.tx_busy) begin
          start   = 1'b1;
          state_d = WAIT;
        end else if (wd_q == WD_MAX) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end else begin
          start = 1'b1;
          wd_d  = wd_q + 1'b1;
        end
      end
      WAIT: begin
        if (tx_if.tx_done) begin
          cnt_d = cnt_q + 1'b1;
`ifdef UART_TX_GAP_EN
          gap_d   = gap_i;
          state_d = GAP;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef UART_TX_GAP_EN
      GAP: begin
        if (baud_en_i) begin
          if (gap_q == '0) state_d = IDLE;
          else             gap_d   = gap_q - 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Pulses are suppressed in a reset cycle even if the old state would raise them.
  assign fifo_pop_o    = pop   && !rst_i;
  assign tx_if.tx_start = start && !rst_i;
  assign req_drop_o    = drop  && !rst_i;
  assign timeout_o     = tmo   && !rst_i;
  assign tx_if.tx_data = data_q;
  assign tx_if.tx_conf = conf_q;
  assign ctrl_busy_o   = (state_q != IDLE);
  assign char_count_o  = cnt_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with FIFO / transmit-module models and a start scoreboard.
module tb_uart_tx_ctrl;
  localparam int DW = 8, CW = 5, NW = 16, TO = 15, GW = 4, BUSY_CYC = 12, LIM = 600;

  logic clk = 1'b0;
  logic rst, baud_en, tx_en, fifo_en, tx_req, fifo_empty;
  logic [CW-1:0] tx_conf;
  logic [DW-1:0] tx_data, fifo_data;
  logic [GW-1:0] gap;
  logic fifo_pop, ctrl_busy, req_drop, tmo;
  logic [NW-1:0] char_count;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DW(DW), .CW(CW)) tx_if ();

  uart_tx_ctrl #(
    .MAX_UART_DATA_W(DW), .TOTAL_CONF_W(CW), .CHAR_COUNT_W(NW),
    .START_TIMEOUT(TO), .GAP_W(GW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .baud_en_i(baud_en), .tx_en_i(tx_en),
    .tx_fifo_en_i(fifo_en), .tx_conf_i(tx_conf), .tx_req_i(tx_req),
    .tx_data_i(tx_data), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .gap_i(gap), .fifo_pop_o(fifo_pop), .ctrl_busy_o(ctrl_busy),
    .req_drop_o(req_drop), .timeout_o(tmo), .char_count_o(char_count),
    .tx_if(tx_if)
  );

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [DW+CW-1:0] exp_q[$];
  logic [DW-1:0]    fq[$];
  int  cyc = 0, pop_cnt = 0, start_cyc = -1, tmo_cyc = -1, busy_left = 0, ticks = 0;
  bit  dead = 0, pop_prev = 0, start_prev = 0, pend = 0, done_seen = 0, track_gap = 0;

  // FIFO model, transmit-module model and start-time scoreboard, all on the falling edge.
  always @(negedge clk) begin
    logic [DW+CW-1:0] e;
    cyc++;
    if (fifo_pop) begin
      pop_cnt++;
      check("pop_width", 32'(pop_prev), 32'd0);
    end
    if (tx_if.tx_start && !start_prev) begin
      start_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_if.tx_data), 32'(e[DW+CW-1:CW]));
        check("tx_conf", 32'(tx_if.tx_conf), 32'(e[CW-1:0]));
      end
`ifdef UART_TX_GAP_EN
      if (track_gap) check("gap_ticks_ge4", 32'(ticks >= 4), 32'd1);
`endif
      track_gap = 0;
    end
    if (tmo) begin
      tmo_cyc = cyc;
      check("start_low_at_timeout", 32'(tx_if.tx_start), 32'd0);
    end
    if (done_seen) begin
`ifdef UART_TX_GAP_EN
      check("busy_in_gap", 32'(ctrl_busy), 32'd1);
`else
      check("idle_after_done", 32'(ctrl_busy), 32'd0);
`endif
      done_seen = 0;
    end
    if (pend && fq.size() > 0) fq.delete(0);
    pend = fifo_pop;
    baud_en = (cyc % 3 == 0);
    if (baud_en && track_gap) ticks++;
    tx_if.tx_done = 1'b0;
    if (rst) begin
      tx_if.tx_busy = 1'b0;
      busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        tx_if.tx_busy = 1'b0;
        tx_if.tx_done = 1'b1;
        done_seen = 1;
        track_gap = 1;
        ticks = 0;
      end
    end else if (tx_if.tx_start && !dead && !tx_if.tx_busy) begin
      tx_if.tx_busy = 1'b1;
      busy_left = BUSY_CYC;
    end
    start_prev = tx_if.tx_start;
    pop_prev   = fifo_pop;
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? '0 : fq[0];
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"},     32'(fifo_pop), 32'd0);
    check({tag, "_start"},   32'(tx_if.tx_start), 32'd0);
    check({tag, "_data"},    32'(tx_if.tx_data), 32'd0);
    check({tag, "_conf"},    32'(tx_if.tx_conf), 32'd0);
    check({tag, "_busy"},    32'(ctrl_busy), 32'd0);
    check({tag, "_drop"},    32'(req_drop), 32'd0);
    check({tag, "_timeout"}, 32'(tmo), 32'd0);
    check({tag, "_count"},   32'(char_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    int n, base;
    logic [DW-1:0] vals [3];
    rst = 1; tx_en = 0; fifo_en = 0; tx_req = 0; tx_conf = '0; tx_data = '0;
    gap = 4'd3; baud_en = 0; fifo_empty = 1; fifo_data = '0;
    tx_if.tx_busy = 0; tx_if.tx_done = 0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 0;

    // FIFO mode, three characters
    vals = '{8'h55, 8'hA3, 8'h0F};
    tx_conf = 5'b11_00_1; fifo_en = 1; tx_en = 1;
    foreach (vals[i]) begin
      fq.push_back(vals[i]);
      exp_q.push_back({vals[i], 5'b11_00_1});
    end
    n = 0;
    while (!(pop_cnt == 3 && !ctrl_busy && fq.size() == 0) && n < LIM) begin step(); n++; end
    check("wait_fifo_done", 32'(n < LIM), 32'd1);
    check("fifo_pops", 32'(pop_cnt), 32'd3);
    check("fifo_count", 32'(char_count), 32'd3);
    check("fifo_idle", 32'(ctrl_busy), 32'd0);
    check("fifo_sb_empty", 32'(exp_q.size()), 32'd0);

    // Direct mode: one accepted, one dropped while busy
    fifo_en = 0; tx_data = 8'h7E; tx_req = 1;
    exp_q.push_back({8'h7E, 5'b11_00_1});
    #1 check("direct_first_drop", 32'(req_drop), 32'd0);
    step(); tx_req = 0;
    repeat (9) step();
    tx_data = 8'h11; tx_req = 1;
    #1 check("direct_second_drop", 32'(req_drop), 32'd1);
    step(); tx_req = 0;
    #1 check("direct_drop_1cycle", 32'(req_drop), 32'd0);
    n = 0;
    while (ctrl_busy && n < LIM) begin step(); n++; end
    check("wait_direct_done", 32'(n < LIM), 32'd1);
    check("direct_count", 32'(char_count), 32'd4);
    step();
    tx_en = 0; tx_req = 1;
    #1 check("drop_when_disabled", 32'(req_drop), 32'd1);
    step(); tx_req = 0; tx_en = 1; fifo_en = 1; tx_req = 1;
    #1 check("fifo_mode_req_no_drop", 32'(req_drop), 32'd0);
    step(); tx_req = 0;
    check("fifo_mode_req_ignored", 32'(ctrl_busy), 32'd0);

    // tx_en dropped while a character is in flight
    base = pop_cnt; tx_conf = 5'b01_10_0;
    fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
    exp_q.push_back({8'hA1, 5'b01_10_0});
    n = 0;
    while (!tx_if.tx_busy && n < LIM) begin step(); n++; end
    check("wait_en_busy", 32'(n < LIM), 32'd1);
    tx_en = 0;
    n = 0;
    while (ctrl_busy && n < LIM) begin step(); n++; end
    check("wait_en_done", 32'(n < LIM), 32'd1);
    repeat (20) step();
    check("en_drop_pops", 32'(pop_cnt - base), 32'd1);
    check("en_drop_occupancy", 32'(fq.size()), 32'd2);
    check("en_drop_count", 32'(char_count), 32'd5);

    // Reset while waiting on the transmit module
    fq.delete();
    base = pop_cnt;
    fq.push_back(8'hC3);
    exp_q.push_back({8'hC3, 5'b01_10_0});
    tx_en = 1;
    n = 0;
    while (!tx_if.tx_busy && n < LIM) begin step(); n++; end
    check("wait_rst_busy", 32'(n < LIM), 32'd1);
    rst = 1;
    step();
    check_all_zero("rst_wait");
    rst = 0;
    fq.push_back(8'h3C);
    exp_q.push_back({8'h3C, 5'b01_10_0});
    n = 0;
    while (!(pop_cnt - base == 2 && !ctrl_busy && fq.size() == 0) && n < LIM) begin step(); n++; end
    check("wait_after_rst", 32'(n < LIM), 32'd1);
    check("after_rst_pops", 32'(pop_cnt - base), 32'd2);
    check("after_rst_count", 32'(char_count), 32'd1);

    // Start watchdog: transmit module never goes busy
    dead = 1; base = pop_cnt; tmo_cyc = -1;
    fq.push_back(8'h99);
    exp_q.push_back({8'h99, 5'b01_10_0});
    n = 0;
    while (tmo_cyc < 0 && n < LIM) begin step(); n++; end
    check("wait_timeout", 32'(n < LIM), 32'd1);
    check("timeout_latency", 32'(tmo_cyc - start_cyc), 32'(TO));
    step();
    check("timeout_pulse_1cycle", 32'(tmo), 32'd0);
    check("timeout_idle", 32'(ctrl_busy), 32'd0);
    check("timeout_start_low", 32'(tx_if.tx_start), 32'd0);
    check("timeout_count", 32'(char_count), 32'd1);
    check("timeout_pops", 32'(pop_cnt - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Sequencing controller that feeds characters to the UART transmit module, from either a first-word-fall-through Tx FIFO or a direct single-character request. It owns all Tx FIFO pop control, so the transmit module's internal FIFO pop is unused and its FIFO enable input is tied low. It latches data and configuration per character, drives the start handshake and tracks completion, with a start-acknowledge watchdog. It sits between the register/FIFO layer and the transmit module.

Parameters:
MAX_UART_DATA_W, 8, width of a UART character
TOTAL_CONF_W, 5, width of the Tx configuration word {data[1:0], stop[1:0], parity_en}
CHAR_COUNT_W, 16, width of the transmitted-character counter
START_TIMEOUT, 1023, clocks to wait for tx_busy_i after raising tx_start_o before aborting
GAP_W, 4, width of the inter-character gap field (used only with the optional feature)

Ports:
clk_i  in  1  top clock
rst_i  in  1  synchronous active-high reset
baud_en_i  in  1  baud-rate tick; used only by the gap counter
tx_en_i  in  1  controller enable
tx_fifo_en_i  in  1  1 = FIFO mode, 0 = direct mode
tx_conf_i  in  TOTAL_CONF_W  configuration; latched per character
tx_req_i  in  1  direct-mode send strobe (1-cycle pulse)
tx_data_i  in  MAX_UART_DATA_W  direct-mode data
fifo_empty_i  in  1  Tx FIFO empty
fifo_data_i  in  MAX_UART_DATA_W  FIFO head; valid while fifo_empty_i = 0
gap_i  in  GAP_W  inter-character gap in baud ticks (optional feature only)
tx_busy_i  in  1  transmit-module busy
tx_done_i  in  1  transmit-module done pulse
fifo_pop_o  out  1  1-cycle FIFO pop
tx_start_o  out  1  start request to the transmit module
tx_data_o  out  MAX_UART_DATA_W  latched character
tx_conf_o  out  TOTAL_CONF_W  latched configuration
ctrl_busy_o  out  1  high in every state except IDLE
req_drop_o  out  1  1-cycle pulse: direct request ignored
timeout_o  out  1  1-cycle pulse: start watchdog expired
char_count_o  out  CHAR_COUNT_W  characters completed, wraps to 0 after all-ones

Behaviour:
- Reset: all outputs 0; state IDLE; watchdog, gap and character counters cleared. Reset overrides any operation in progress; no pop or pulse is emitted in the reset cycle.
- FSM states: IDLE, LOAD, START, WAIT, GAP.
- IDLE:
  - FIFO mode: tx_en_i=1 and fifo_empty_i=0 -> LOAD.
  - Direct mode: tx_en_i=1 and tx_req_i=1 -> LOAD, capturing tx_data_i.
- LOAD (1 cycle):
  - tx_data_o is loaded from fifo_data_i (FIFO mode) or from the captured direct data.
  - tx_conf_o <= tx_conf_i.
  - FIFO mode only: fifo_pop_o pulses high for exactly this cycle.
  - Next state START.
- START:
  - tx_start_o=1; watchdog counts clocks.
  - tx_busy_i=1 -> tx_start_o=0 the next cycle; go to WAIT.
  - Watchdog reaches START_TIMEOUT -> timeout_o pulses; tx_start_o drops; go to IDLE. The character is lost and char_count_o is not incremented.
- WAIT:
  - tx_start_o=0; tx_data_o and tx_conf_o are held stable.
  - tx_done_i=1 -> char_count_o+1; go to GAP with the optional feature, otherwise IDLE.
- Latency: one FIFO pop per character, with pop-to-tx_start_o of 1 clock. A new character may enter LOAD no earlier than 1 cycle after tx_done_i.
- Direct request when state is not IDLE, or when tx_en_i=0 -> request ignored and req_drop_o pulses in the same cycle. In FIFO mode tx_req_i is ignored without any pulse.
- tx_en_i dropping mid-character: the current character completes normally; the FSM then returns to IDLE and stays there, with no further pops.
- tx_fifo_en_i, tx_conf_i or tx_data_i changing after LOAD has no effect until the next LOAD.
- A FIFO that empties during a character causes no action; the FSM idles in IDLE after completion.
- A tx_done_i arriving outside WAIT is ignored.

Optional Feature:
UART_TX_GAP_EN
- Defined: GAP state is compiled in. On entering GAP, the gap counter is loaded with gap_i and decremented on each baud_en_i. The FSM goes to IDLE when the counter is 0 at a baud tick. gap_i=0 gives a 1-baud-tick stay in GAP. ctrl_busy_o stays 1 during GAP.
- Not defined: GAP state, gap counter and gap_i use are removed; gap_i is left unused. WAIT goes directly to IDLE on tx_done_i.

Test Plan:
- FIFO mode, 3 entries 0x55, 0xA3, 0x0F, conf 5'b11_00_1, transmit-module model -> exactly 3 single-cycle pops; tx_data_o takes each value in order; char_count_o=3; ctrl_busy_o=0 after the last tx_done_i.
- Direct mode, tx_req_i with 0x7E, then a second tx_req_i 10 cycles later -> first character sent; second request produces req_drop_o=1 for 1 cycle; char_count_o=1.
- Transmit model never asserts busy, START_TIMEOUT=15 -> timeout_o pulses 15 clocks after tx_start_o rises; state IDLE; char_count_o=0; one pop consumed.
- tx_en_i deasserted while WAIT, FIFO holding 2 more entries -> current character completes; no further pops; FIFO occupancy stays 2.
- rst_i asserted in WAIT -> next cycle all outputs 0 and state IDLE. After release with FIFO non-empty -> normal LOAD with a single pop.
- UART_TX_GAP_EN defined, gap_i=3 -> tx_start_o for the next character rises no earlier than 4 baud ticks after tx_done_i. Not defined -> LOAD follows 1 cycle after tx_done_i.
